// File: rtl/mult_issue_seq.sv
// mult_issue_seq: operand FIFO plus sequencer for an 8-bit shift-add multiplier.
// Each queued pair is run as rearm, launch, wait for done, then capture.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand pair handshake (in_a multiplier, in_b multiplicand)
//   out_valid/out_ready   result handshake (out_product, out_err on timeout)
//   mul_reset, mul_start  rearm pulse and start level to the multiplier
//   mul_multiplier/cand   operands held for the multiplier
//   mul_product, mul_done multiplier result and sticky done flag
//   busy                  sequencer active or operands still queued
module mult_issue_seq #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH:0]   out_product,
  output logic               out_err,
  output logic               mul_reset,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic [WIDTH-1:0]   mul_multiplicand,
  input  logic [2*WIDTH:0]   mul_product,
  input  logic               mul_done,
  output logic               busy
);

  localparam int PW = 2*WIDTH+1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LAUNCH,
    S_CAPTURE,
    S_ABORT,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_fill;

  logic [CW-1:0]    r_tmo;
  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_b;
  logic             r_mul_reset;
  logic             r_mul_start;
  logic             r_out_valid;
  logic [PW-1:0]    r_out_product;
  logic             r_out_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_tmo_nxt;
  logic [WIDTH-1:0] w_mul_a_nxt;
  logic [WIDTH-1:0] w_mul_b_nxt;
  logic             w_mul_reset_nxt;
  logic             w_mul_start_nxt;
  logic             w_out_valid_nxt;
  logic [PW-1:0]    w_out_product_nxt;
  logic             w_out_err_nxt;

  assign w_full  = (r_fill == FILL_FULL);
  assign w_empty = (r_fill == '0);

  // Gated by reset so nothing is accepted in the reset cycle itself.
  assign in_ready = ~reset & ~w_full;
  assign w_push   = in_valid & in_ready;

  assign out_valid        = r_out_valid;
  assign out_product      = r_out_product;
  assign out_err          = r_out_err;
  assign mul_reset        = r_mul_reset;
  assign mul_start        = r_mul_start;
  assign mul_multiplier   = r_mul_a;
  assign mul_multiplicand = r_mul_b;
  assign busy             = (r_state != S_IDLE) | ~w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= in_a;
      r_mem_b[r_wptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_fill <= r_fill + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_tmo         <= '0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_reset   <= 1'b1;
      r_mul_start   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_out_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tmo         <= w_tmo_nxt;
      r_mul_a       <= w_mul_a_nxt;
      r_mul_b       <= w_mul_b_nxt;
      r_mul_reset   <= w_mul_reset_nxt;
      r_mul_start   <= w_mul_start_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_product <= w_out_product_nxt;
      r_out_err     <= w_out_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pop             = 1'b0;
    w_tmo_nxt         = r_tmo;
    w_mul_a_nxt       = r_mul_a;
    w_mul_b_nxt       = r_mul_b;
    w_mul_reset_nxt   = 1'b0;
    w_mul_start_nxt   = r_mul_start;
    w_out_valid_nxt   = r_out_valid;
    w_out_product_nxt = r_out_product;
    w_out_err_nxt     = r_out_err;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop           = 1'b1;
          w_mul_a_nxt     = r_mem_a[r_rptr];
          w_mul_b_nxt     = r_mem_b[r_rptr];
          // Registered, so the rearm pulse lines up with the CLR cycle.
          w_mul_reset_nxt = 1'b1;
          w_state_nxt     = S_CLR;
        end
      end
      S_CLR: begin
        // A done seen here is stale from the previous op and is ignored.
        w_tmo_nxt       = '0;
        w_mul_start_nxt = 1'b1;
        w_state_nxt     = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (mul_done) begin
          w_mul_start_nxt = 1'b0;
          w_state_nxt     = S_CAPTURE;
        end else if (r_tmo == TMO_LAST) begin
          w_mul_start_nxt = 1'b0;
          w_state_nxt     = S_ABORT;
        end else begin
          w_tmo_nxt = r_tmo + CW'(1);
        end
      end
      S_CAPTURE: begin
        w_out_product_nxt = mul_product;
        w_out_err_nxt     = 1'b0;
        w_out_valid_nxt   = 1'b1;
        w_mul_start_nxt   = 1'b0;
        w_state_nxt       = S_HOLD;
      end
      S_ABORT: begin
        w_out_product_nxt = '0;
        w_out_err_nxt     = 1'b1;
        w_out_valid_nxt   = 1'b1;
        w_mul_start_nxt   = 1'b0;
        w_state_nxt       = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_issue_seq.sv
// tb_mult_issue_seq: random and directed stimulus for mult_issue_seq,
// with a behavioural multiplier and an in-order result scoreboard.
module tb_mult_issue_seq;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int TO = 40;
  localparam int PW = 2*W+1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_product;
  logic          out_err;
  logic          mul_reset;
  logic          mul_start;
  logic [W-1:0]  mul_multiplier;
  logic [W-1:0]  mul_multiplicand;
  logic [PW-1:0] mul_product;
  logic          mul_done;
  logic          busy;

  always #5 clk = ~clk;

  mult_issue_seq #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .out_err          (out_err),
    .mul_reset        (mul_reset),
    .mul_start        (mul_start),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_product      (mul_product),
    .mul_done         (mul_done),
    .busy             (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural multiplier: done (sticky) mlat start cycles after launch.
  int            mlat = 9;
  bit            hang_en = 1'b0;
  int            m_cnt;
  logic          m_done;
  logic [PW-1:0] m_prod;

  assign mul_done    = m_done;
  assign mul_product = m_prod;

  always @(posedge clk) begin
    if (mul_reset) begin
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (mul_start && !m_done) begin
      if (!(hang_en && mul_multiplier == 8'hEE && mul_multiplicand == 8'hEE)
          && m_cnt == mlat-1) begin
        m_done <= 1'b1;
        m_prod <= PW'(mul_multiplier) * PW'(mul_multiplicand);
      end
      m_cnt <= m_cnt + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: every accepted pair yields one result, in order.
  typedef struct packed {
    logic          err;
    logic [PW-1:0] prod;
  } exp_t;
  exp_t q[$];
  int   n_res = 0;
  int   rst_run = 0;
  bit   after_rst = 1'b1;

  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (reset) begin
      q.delete();
      rst_run   = 0;
      after_rst = 1'b1;
    end else begin
      if (in_valid && in_ready) begin
        e.err  = hang_en && in_a == 8'hEE && in_b == 8'hEE;
        e.prod = e.err ? '0 : PW'(in_a) * PW'(in_b);
        q.push_back(e);
      end
      if (out_valid && out_ready) begin
        n_res++;
        if (q.size() == 0) begin
          check("extra_result", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          check("product", 32'(out_product), 32'(e.prod));
          check("err", 32'(out_err), 32'(e.err));
        end
      end
      if (out_valid) check("start_low_at_result", 32'(mul_start), 32'(0));
      if (mul_reset) begin
        rst_run++;
      end else begin
        if (rst_run > 0 && !after_rst)
          check("mul_reset_width", 32'(rst_run), 32'(1));
        rst_run   = 0;
        after_rst = 1'b0;
      end
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    #1;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("push_accept", 32'(in_ready), 32'(1));
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int t);
    int g = 0;
    while (!out_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("wait_valid", 32'(out_valid), 32'(1));
    t = cyc;
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    while ((q.size() != 0 || busy || out_valid) && g < 3000) begin
      @(negedge clk);
      #3;
      g++;
    end
    check("drain", 32'(q.size() == 0 && !busy), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t0, t1, t2, nv, base, g;
    logic [PW-1:0] exp2 [3];
    exp2[0] = 17'd182;
    exp2[1] = 17'd816;
    exp2[2] = 17'd7448;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_product", 32'(out_product), 32'(0));
    check("rst_out_err", 32'(out_err), 32'(0));
    check("rst_mul_start", 32'(mul_start), 32'(0));
    check("rst_mul_reset", 32'(mul_reset), 32'(1));
    check("rst_mul_a", 32'(mul_multiplier), 32'(0));
    check("rst_mul_b", 32'(mul_multiplicand), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));

    // 1: single op, latency push->out_valid = IDLE+CLR+(mlat+1)+CAPTURE
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 8'd2;
    in_b = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t1_latency", 32'(k - 1), 32'(3 + mlat + 1));
    check("t1_product", 32'(out_product), 32'(6));
    check("t1_err", 32'(out_err), 32'(0));
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(out_valid), 32'(0));
    drain();

    // 2: back-to-back, in order, one result per (launch cycles + 4)
    push(8'd14, 8'd13);
    push(8'd24, 8'd34);
    push(8'd76, 8'd98);
    idle_in();
    wait_valid(t0);
    check("t2_prod0", 32'(out_product), 32'(exp2[0]));
    @(negedge clk);
    wait_valid(t1);
    check("t2_prod1", 32'(out_product), 32'(exp2[1]));
    @(negedge clk);
    wait_valid(t2);
    check("t2_prod2", 32'(out_product), 32'(exp2[2]));
    check("t2_interval1", 32'(t1 - t0), 32'(mlat + 1 + 4));
    check("t2_interval2", 32'(t2 - t1), 32'(mlat + 1 + 4));
    drain();

    // 3: extremes
    push(8'd255, 8'd255);
    push(8'd0, 8'd200);
    idle_in();
    wait_valid(t0);
    check("t3_max", 32'(out_product), 32'(65025));
    @(negedge clk);
    wait_valid(t0);
    check("t3_zero", 32'(out_product), 32'(0));
    drain();

    // 4: consumer stalled; FIFO plus the in-flight op fill up, then stall
    base = n_res;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < D + 1; i++) begin
      in_valid = 1'b1;
      in_a = 8'(10 + i);
      in_b = 8'(20 + 3*i);
      #1;
      check("t4_ready", 32'(in_ready), 32'(1));
      @(negedge clk);
    end
    in_a = 8'd50;
    in_b = 8'd60;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("t4_stall", 32'(in_ready), 32'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    g = 0;
    #1;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    idle_in();
    drain();
    check("t4_count", 32'(n_res - base), 32'(D + 2));

    // 5: hung multiplier -> abort after TO launch cycles, next op fine
    hang_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 8'hEE;
    in_b = 8'hEE;
    @(negedge clk);
    in_a = 8'd7;
    in_b = 8'd9;
    k = 1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 2;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5_latency", 32'(k - 1), 32'(3 + TO));
    check("t5_err", 32'(out_err), 32'(1));
    check("t5_prod", 32'(out_product), 32'(0));
    @(negedge clk);
    wait_valid(t0);
    check("t5_next_prod", 32'(out_product), 32'(63));
    check("t5_next_err", 32'(out_err), 32'(0));
    drain();
    hang_en = 1'b0;

    // 6: reset while launching, with two ops queued behind
    push(8'd101, 8'd102);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    idle_in();
    g = 0;
    while (!mul_start && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("t6_launch_seen", 32'(mul_start), 32'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_mul_reset_in_rst", 32'(mul_reset), 32'(1));
    reset = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'(0));
    check("t6_in_ready", 32'(in_ready), 32'(1));
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("t6_no_valid", 32'(nv), 32'(0));
    push(8'd101, 8'd102);
    idle_in();
    wait_valid(t0);
    check("t6_fresh", 32'(out_product), 32'(10302));
    drain();

    // Random traffic with a random multiplier latency
    mlat = $urandom_range(1, 12);
    repeat (600) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
